// File: rtl/apb_reg_bank_if.sv
// APB3/APB4 slave-side bus bundle for apb_reg_bank.
interface apb_reg_bank_if #(parameter int ADDRWIDTH = 12);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_reg_bank.sv
// Parametrised APB slave register bank with wait states, PSLVERR and a PrimeCell ID window.
// Optional byte-strobe write path: define APB_REG_BANK_WSTRB_EN.
module apb_reg_bank #(
  parameter int          ADDRWIDTH   = 12,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [3:0]               ecorevnum,
  apb_reg_bank_if.slave            bus,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [10:0] NREG = 11'(NUM_REGS);
  localparam logic [3:0]  NWS  = 4'(WAIT_STATES);

  state_t                       state;
  logic [3:0]                   cnt;
  logic [9:0]                   idx;
  logic                         write_q;
  logic [31:0]                  wdata_q;
  logic [NUM_REGS-1:0][31:0]    regs;
  logic [NUM_REGS-1:0]          we;
  logic [31:0]                  wmask, reg_rd, id_rd;
  logic                         complete, reg_hit, id_hit, strb_err, err, commit;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx     <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.psel && !bus.penable) begin
          state   <= ACCESS;
          cnt     <= NWS;
          idx     <= bus.paddr[11:2];
          write_q <= bus.pwrite;
          wdata_q <= bus.pwdata;
        end
        ACCESS: begin
          // psel dropping mid-transfer is an abort: no write, no response
          if (!bus.psel)        state <= IDLE;
          else if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else                  state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_REG_BANK_WSTRB_EN
  logic [3:0] strb_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                                     strb_q <= 4'h0;
    else if (state == IDLE && bus.psel && !bus.penable) strb_q <= bus.pstrb;
  end
  assign wmask    = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
  assign strb_err = !write_q && (strb_q != 4'h0);
`else
  logic unused_strb;
  assign unused_strb = ^bus.pstrb;
  assign wmask       = '1;
  assign strb_err    = 1'b0;
`endif

  assign complete = (state == ACCESS) && (cnt == 4'd0) && bus.psel;
  assign reg_hit  = {1'b0, idx} < NREG;
  assign id_hit   = idx >= 10'h3F4;
  assign err      = strb_err || !(reg_hit || (id_hit && !write_q));
  assign commit   = complete && write_q && !err;

  always_comb begin
    reg_rd = '0;
    we     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 10'(i)) begin
        reg_rd = regs[i];
        we[i]  = commit;
      end
    end
  end

  // ID window order is PID4..7, PID0..3, CID0..3 from 0xFD0 upwards
  always_comb begin
    case (idx[3:0])
      4'h4:    id_rd = 32'h04;
      4'h8:    id_rd = 32'h19;
      4'h9:    id_rd = 32'hB8;
      4'hA:    id_rd = 32'h1B;
      4'hB:    id_rd = {24'h0, ecorevnum, 4'h0};
      4'hC:    id_rd = 32'h0D;
      4'hD:    id_rd = 32'hF0;
      4'hE:    id_rd = 32'h05;
      4'hF:    id_rd = 32'hB1;
      default: id_rd = 32'h0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      regs     <= {NUM_REGS{RESET_VALUE}};
      wr_pulse <= '0;
    end else begin
      wr_pulse <= we;
      for (int i = 0; i < NUM_REGS; i++)
        if (we[i]) regs[i] <= (regs[i] & ~wmask) | (wdata_q & wmask);
    end
  end

  assign reg_q       = regs;
  assign bus.pready  = complete;
  assign bus.pslverr = complete && err;
  assign bus.prdata  = (complete && !write_q && !err) ? (reg_hit ? reg_rd : id_rd) : 32'h0;

endmodule
